rs_enc_tap_cell: RTL and testbench

- One delay/multiply stage of the systematic Reed-Solomon (CCSDS-style) LFSR parity generator over GF(2^8).
- A chain of these cells, with all stages sharing one feedback symbol, forms the encoder remainder register.
- Parameter LAST=0 gives an interior tap. LAST=1 gives the final (highest-order) tap, which also registers the data input and supplies the pre-feedback symbol.
- The enclosing encoder forms fb = pre_fbOut ^ dInp_reg and broadcasts it to every cell's feedb.

---
 rtl/rs_enc_tap_cell_if.sv | 24 ++
 rtl/rs_enc_tap_cell.sv | 94 +++++++++
 tb/tb_rs_enc_tap_cell.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_enc_tap_cell_if.sv
// Bundles the clock enable, the feedback/shift path and the last-tap data path
// of a Reed-Solomon encoder tap so that taps can be wired to a controller.
interface rs_enc_tap_cell_if #(
  parameter int MM = 8
);
  logic          clkEn;
  logic [MM-1:0] feedb;
  logic [MM-1:0] shftIn;
  logic [MM-1:0] shftOut;
  logic          hold0fb;
  logic [MM-1:0] dInp;
  logic [MM-1:0] pre_fbOut;
  logic [MM-1:0] dInp_reg;

  modport master (
    output clkEn, feedb, shftIn, hold0fb, dInp,
    input  shftOut, pre_fbOut, dInp_reg
  );

  modport slave (
    input  clkEn, feedb, shftIn, hold0fb, dInp,
    output shftOut, pre_fbOut, dInp_reg
  );
endinterface

// File: rtl/rs_enc_tap_cell.sv
// One tap of a systematic RS LFSR parity generator over GF(2^8), field 0x187:
// R <= shftIn ^ GG*feedb. The last tap also registers the message symbol.
module rs_enc_tap_cell #(
  parameter int       MM   = 8,
  parameter logic [7:0] GG   = 8'd1,
  parameter bit       LAST = 1'b0
) (
  input logic              clk,
  input logic              rst,
  rs_enc_tap_cell_if.slave sif
);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6] ^ a[7], a[5:2], a[1] ^ a[7], a[0] ^ a[7], a[7]};
  endfunction

  // Shift-and-add multiply of the operand by the constant coefficient GG.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (GG[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  logic [MM-1:0] prod_s;
  logic [MM-1:0] r_d;
  logic [MM-1:0] r_q;

  assign prod_s = gf_mul_const(sif.feedb);

  // Next remainder value, held when the enable is low.
  always_comb begin
    r_d = r_q;
    if (sif.clkEn) begin
      r_d = sif.shftIn ^ prod_s;
    end else begin
      r_d = r_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign sif.shftOut = r_q;

  if (LAST) begin : g_last
    logic [MM-1:0] d_d;
    logic [MM-1:0] d_q;

    // Next message-symbol register value.
    always_comb begin
      d_d = d_q;
      if (sif.clkEn) begin
        d_d = sif.dInp;
      end else begin
        d_d = d_q;
      end
    end

    // Message-symbol register feeding the encoder's feedback sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        d_q <= '0;
      end else begin
        d_q <= d_d;
      end
    end

    // Combinational so the parity phase can kill feedback in the same cycle.
    assign sif.pre_fbOut = sif.hold0fb ? '0 : r_q;
    assign sif.dInp_reg  = d_q;
  end else begin : g_interior
    logic unused_last_inputs;
    assign unused_last_inputs = sif.hold0fb ^ (^sif.dInp);
    assign sif.pre_fbOut      = '0;
    assign sif.dInp_reg       = '0;
  end

endmodule

// File: tb/tb_rs_enc_tap_cell.sv
// Directed checks of single taps plus a 32-tap CCSDS encoder chain compared
// against a long-division model of m(x)*x^32 mod g(x) over GF(2^8)/0x187.
module tb_rs_enc_tap_cell;

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    logic [7:0] r;
    r = {a[6:0], 1'b0};
    if (a[7]) r = r ^ 8'h87;
    return r;
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = tb_xtime(sh);
    end
    return acc;
  endfunction

  function automatic logic [7:0] tb_alpha_pow(input int e);
    logic [7:0] a;
    a = 8'h01;
    for (int i = 0; i < e; i++) a = tb_xtime(a);
    return a;
  endfunction

  // g(x) = prod_{j=112..143} (x + alpha^(11j)); coefficient k in bits [8k+:8].
  function automatic logic [263:0] gen_poly();
    logic [263:0] g;
    logic [7:0]   r;
    logic [7:0]   cur;
    logic [7:0]   prev;
    g = '0;
    g[7:0] = 8'h01;
    for (int j = 112; j <= 143; j++) begin
      r = tb_alpha_pow((11 * j) % 255);
      prev = 8'h00;
      for (int i = 0; i <= 32; i++) begin
        cur = g[i*8 +: 8];
        g[i*8 +: 8] = prev ^ tb_gmul(r, cur);
        prev = cur;
      end
    end
    return g;
  endfunction

  localparam logic [263:0] GPOLY = gen_poly();

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       s_en;
  logic [7:0] s_fb;
  logic [7:0] s_in;
  logic       s_hold;
  logic [7:0] s_din;

  rs_enc_tap_cell_if #(.MM(8)) if_a ();
  rs_enc_tap_cell_if #(.MM(8)) if_b ();
  rs_enc_tap_cell_if #(.MM(8)) if_c ();
  rs_enc_tap_cell_if #(.MM(8)) if_d ();

  assign if_a.clkEn = s_en;  assign if_a.feedb = s_fb;  assign if_a.shftIn = s_in;
  assign if_a.hold0fb = s_hold;  assign if_a.dInp = s_din;
  assign if_b.clkEn = s_en;  assign if_b.feedb = s_fb;  assign if_b.shftIn = s_in;
  assign if_b.hold0fb = s_hold;  assign if_b.dInp = s_din;
  assign if_c.clkEn = s_en;  assign if_c.feedb = s_fb;  assign if_c.shftIn = s_in;
  assign if_c.hold0fb = s_hold;  assign if_c.dInp = s_din;
  assign if_d.clkEn = s_en;  assign if_d.feedb = s_fb;  assign if_d.shftIn = s_in;
  assign if_d.hold0fb = s_hold;  assign if_d.dInp = s_din;

  rs_enc_tap_cell #(.MM(8), .GG(8'd2),  .LAST(1'b0)) u_a (.clk(clk), .rst(rst), .sif(if_a.slave));
  rs_enc_tap_cell #(.MM(8), .GG(8'd3),  .LAST(1'b0)) u_b (.clk(clk), .rst(rst), .sif(if_b.slave));
  rs_enc_tap_cell #(.MM(8), .GG(8'd91), .LAST(1'b0)) u_c (.clk(clk), .rst(rst), .sif(if_c.slave));
  rs_enc_tap_cell #(.MM(8), .GG(8'd91), .LAST(1'b1)) u_d (.clk(clk), .rst(rst), .sif(if_d.slave));

  // 32-tap encoder chain.
  logic       ch_en;
  logic       ch_hold;
  logic [7:0] ch_din;
  logic [7:0] ch_fb;
  logic [7:0] ch_pre;
  logic [7:0] ch_dreg;
  logic [7:0] ch_out [32];

  assign ch_fb = ch_pre ^ ch_dreg;

  for (genvar k = 0; k < 32; k++) begin : g_cell
    rs_enc_tap_cell_if #(.MM(8)) ifc ();
    assign ifc.clkEn   = ch_en;
    assign ifc.feedb   = ch_fb;
    assign ifc.hold0fb = ch_hold;
    assign ifc.dInp    = ch_din;
    assign ch_out[k]   = ifc.shftOut;
    if (k == 0) begin : g_first
      assign ifc.shftIn = 8'h00;
    end else begin : g_rest
      assign ifc.shftIn = ch_out[k-1];
    end
    if (k == 31) begin : g_top
      assign ch_pre  = ifc.pre_fbOut;
      assign ch_dreg = ifc.dInp_reg;
    end
    rs_enc_tap_cell #(.MM(8), .GG(GPOLY[k*8 +: 8]), .LAST(k == 31))
      u_cell (.clk(clk), .rst(rst), .sif(ifc.slave));
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] msg [223];
  logic [7:0] divd [255];
  logic [7:0] exp_q [$];
  logic [7:0] q;
  logic [7:0] e;

  initial begin
    rst = 1'b1; s_en = 1'b0; s_fb = 8'h00; s_in = 8'h00; s_hold = 1'b0; s_din = 8'h00;
    ch_en = 1'b0; ch_hold = 1'b0; ch_din = 8'h00;
    @(negedge clk); tick(); tick();
    rst = 1'b0;

    // Preload 0xFF, then reset with enable low.
    s_en = 1'b1; s_in = 8'hFF; s_fb = 8'h00; s_din = 8'h5A;
    tick();
    check("preload_a", if_a.shftOut, 8'hFF);
    check("preload_dreg", if_d.dInp_reg, 8'h5A);
    rst = 1'b1; s_en = 1'b0;
    tick();
    check("rst_a", if_a.shftOut, 8'h00);
    check("rst_b", if_b.shftOut, 8'h00);
    check("rst_c", if_c.shftOut, 8'h00);
    check("rst_d", if_d.shftOut, 8'h00);
    check("rst_dreg", if_d.dInp_reg, 8'h00);
    rst = 1'b0;

    s_en = 1'b1; s_in = 8'h00; s_fb = 8'h80;
    tick();
    check("mul_gg2", if_a.shftOut, 8'h87);
    check("mul_gg3", if_b.shftOut, 8'h07);

    s_fb = 8'h01; s_in = 8'h0F;
    tick();
    check("acc_gg91", if_c.shftOut, 8'h54);
    check("acc_gg91_last", if_d.shftOut, 8'h54);
    check("acc_gg2", if_a.shftOut, 8'h0D);
    check("acc_gg3", if_b.shftOut, 8'h0C);

    s_en = 1'b0; s_fb = 8'h55; s_in = 8'h33;
    tick();
    check("hold_c", if_c.shftOut, 8'h54);
    check("hold_a", if_a.shftOut, 8'h0D);

    s_en = 1'b1; s_fb = 8'h00; s_in = 8'h3C; s_din = 8'h00; s_hold = 1'b0;
    tick();
    check("last_preload", if_d.shftOut, 8'h3C);
    check("pre_fb_open", if_d.pre_fbOut, 8'h3C);
    s_hold = 1'b1;
    #1;
    check("pre_fb_held", if_d.pre_fbOut, 8'h00);
    check("interior_pre_fb", if_c.pre_fbOut, 8'h00);
    s_hold = 1'b0; s_din = 8'hA5;
    tick();
    check("dinp_reg", if_d.dInp_reg, 8'hA5);
    check("interior_dinp_reg", if_c.dInp_reg, 8'h00);
    check("gg0_free_path_kept", if_d.shftOut, 8'h3C);
    s_en = 1'b0;

    // Chain: build the expected parity by polynomial long division.
    for (int i = 0; i < 223; i++) msg[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 255; i++) divd[i] = 8'h00;
    for (int i = 0; i < 223; i++) divd[254 - i] = msg[i];
    for (int d = 254; d >= 32; d--) begin
      q = divd[d];
      for (int j = 0; j <= 32; j++) divd[d - 32 + j] = divd[d - 32 + j] ^ tb_gmul(q, GPOLY[j*8 +: 8]);
    end
    for (int i = 31; i >= 0; i--) exp_q.push_back(divd[i]);

    rst = 1'b1;
    tick();
    rst = 1'b0; ch_en = 1'b1; ch_hold = 1'b0;
    for (int i = 0; i < 223; i++) begin
      ch_din = msg[i];
      tick();
    end
    ch_din = 8'h00;
    tick();
    ch_hold = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL parity_queue_empty index=%0d observed=%02h expected=none", i, ch_out[31]);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("parity_%0d", i), ch_out[31], e);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
